gray_column_readout: RTL
========================

# gray_column_readout

Readout-side counterpart to the global Gray-code ramp counter. The ramp counter's Gray value is latched into per-column memories when each column comparator flips. This block sequences through those memories for one row, reads each latched Gray code, converts it to binary, and streams (column, value) pairs downstream over a valid/ready interface. A small internal buffer absorbs backpressure without losing data.

## Interface
Parameters:
- width, 8, bit width of the Gray code and of the binary result
- columns, 16, number of columns read per row (≥ 2)
- AW, $clog2(columns) (derived, not overridable), column address width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  row readout request; sampled only in IDLE
- col_addr  out  AW  column memory address
- col_rd  out  1  column memory read strobe
- col_data  in  width  Gray code; valid the cycle after col_rd (synchronous RAM)
- out_data  out  width  binary-decoded value
- out_col  out  AW  column index of out_data
- out_valid  out  1  out_data/out_col valid
- out_ready  in  1  downstream accepts when high with out_valid
- busy  out  1  row readout in progress
- done  out  1  one-cycle pulse when the row completes

## Operation
- **Reset values:** col_addr=0, col_rd=0, out_data=0, out_col=0, out_valid=0, busy=0, done=0. The FIFO is emptied, the in-flight flag is cleared, and the FSM goes to IDLE.
- **FSM states:** IDLE, READ, DRAIN.
  - IDLE → READ on start=1. Read address resets to 0.
  - READ: issues reads for columns 0..columns-1 in order. After issuing column columns-1 it goes to DRAIN.
  - DRAIN: waits until there is no in-flight read, the FIFO is empty, and the final handshake has completed. It then pulses done and returns to IDLE.
- **start** in READ or DRAIN is ignored; it is neither queued nor allowed to restart the row.
- **Buffer:** 2-entry FIFO of {column, binary value}.
- **Read issue rule:** in READ, col_rd=1 iff (fifo_count − pop + inflight) < 2, where pop = out_valid & out_ready and inflight = col_rd of the previous cycle. This prevents FIFO overflow under any out_ready pattern.
- **Capture:** col_data is sampled only in the cycle after col_rd=1; at all other times it is ignored. The column index is carried alongside the read.
- **Decode:** bin[width-1] = g[width-1]; bin[i] = bin[i+1] ^ g[i] for i = width-2..0. The result is written to the FIFO at the capture edge.
- **Output:** out_valid = FIFO not empty. out_data/out_col present the FIFO head and hold stable while out_valid & !out_ready.
- **busy** is high in READ and DRAIN.
- **done** is high for exactly one cycle (the DRAIN→IDLE transition cycle); busy is low in that cycle.
- **Reset mid-row:** any pending read result is discarded, FIFO contents are lost, and no done is generated.

## Timing
- start high in cycle 0 → col_rd=1, col_addr=0 in cycle 1.
- Read in cycle t → col_data consumed in cycle t+1 → out_valid visible in cycle t+2. Read-to-output latency is 2 cycles.
- With out_ready held at 1: one column per cycle, with col_rd high in cycles 1..columns.
  - For columns=16: out_valid high in cycles 3..18, with out_col 0..15 in order.
  - done in cycle 19; busy high in cycles 1..18.
- Backpressure (out_ready=0): col_rd deasserts within one cycle of the FIFO plus in-flight count reaching 2. Issue resumes in the same cycle that a pop frees space.
- Column order is always ascending, and every column is output exactly once.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.

## Test plan
- **Reset:** assert reset asynchronously mid-cycle → all outputs read 0 immediately; after release, FSM is idle and busy=0.
- **Decode:** memory holds Gray 0x00, 0x01, 0x03, 0x02, 0x80, 0xC0 in columns 0..5 (width=8) → out_data 0, 1, 2, 3, 255, 128 with out_col 0..5.
- **Full throughput (columns=16, out_ready=1):** start in cycle 0 → col_rd in cycles 1..16; out_valid in cycles 3..18 with out_col 0..15; done=1 only in cycle 19; busy low from cycle 19.
- **Backpressure:** drop out_ready in cycles 4..9 → never more than 2 entries buffered plus outstanding reads; out_data held stable; no column lost or duplicated; all 16 columns delivered in order; done after the last handshake.
- **Start while busy:** pulse start in cycles 5 and 12 → ignored. Exactly 16 outputs and one done; a fresh start after done reads columns 0..15 again.
- **Reset mid-row:** reset in cycle 8 → out_valid=0 immediately; no done; the in-flight col_data is not output. A new start performs a complete row from column 0.

Source files
------------

// File: rtl/gray_column_readout.sv
// gray_column_readout
//
// Reads back one row of per-column Gray-code memories. The columns are read
// in ascending order. Each Gray code is converted to binary, and the result
// is streamed downstream as (column, value) pairs over a valid/ready
// interface. A 2-entry FIFO absorbs backpressure. Reads are throttled so that
// the buffered entries plus the outstanding read never exceed the FIFO depth.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      row readout request, sampled only while idle
//   col_addr   column memory address
//   col_rd     column memory read strobe
//   col_data   Gray code from the column memory, valid the cycle after col_rd
//   out_data   binary-decoded value at the FIFO head
//   out_col    column index of out_data
//   out_valid  FIFO head is valid
//   out_ready  downstream accepts when high together with out_valid
//   busy       row readout in progress
//   done       one-cycle pulse when the row has fully drained
module gray_column_readout #(
  parameter  int unsigned width   = 8,
  parameter  int unsigned columns = 16,
  localparam int unsigned AW      = $clog2(columns)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [AW-1:0]    col_addr,
  output logic             col_rd,
  input  logic [width-1:0] col_data,
  output logic [width-1:0] out_data,
  output logic [AW-1:0]    out_col,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_COL = AW'(columns - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Outstanding read: set in the cycle after col_rd, carrying its column index
  logic             inflight_q, inflight_d;
  logic [AW-1:0]    infl_col_q, infl_col_d;

  // 2-entry FIFO of {column, binary value}
  logic [AW-1:0]    fifo_col_q [2];
  logic [AW-1:0]    fifo_col_d [2];
  logic [width-1:0] fifo_val_q [2];
  logic [width-1:0] fifo_val_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic             push;
  logic             pop;
  logic [2:0]       occupancy;

  // Prefix XOR from the MSB down: doubling the shift distance covers all
  // higher bits in log2(width) steps. This gives bin[i] = ^g[width-1:i].
  function automatic logic [width-1:0] gray2bin(input logic [width-1:0] g);
    logic [width-1:0] b;
    b = g;
    for (int unsigned s = 1; s < width; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight_q;

  // Occupancy seen by the next read: entries that remain after this cycle's
  // pop, plus the read already in flight. The strobe is combinational so
  // that issue resumes in the same cycle a pop frees a slot.
  assign occupancy = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
  assign col_rd    = (state_q == READ) && (occupancy < 3'd2);

  assign col_addr  = addr_q;
  assign out_data  = fifo_val_q[rd_ptr_q];
  assign out_col   = fifo_col_q[rd_ptr_q];
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    inflight_d = col_rd;
    infl_col_d = addr_q;
    fifo_col_d = fifo_col_q;
    fifo_val_d = fifo_val_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + 2'(push) - 2'(pop);

    if (push) begin
      fifo_col_d[wr_ptr_q] = infl_col_q;
      fifo_val_d[wr_ptr_q] = gray2bin(col_data);
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          addr_d  = '0;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        if (col_rd) begin
          if (addr_q == LAST_COL) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // No reads are issued here, so inflight_d is already clear. The row
        // ends once the last entry has been handed off.
        if (count_d == 2'd0 && !inflight_d) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      inflight_q    <= 1'b0;
      infl_col_q    <= '0;
      fifo_col_q[0] <= '0;
      fifo_col_q[1] <= '0;
      fifo_val_q[0] <= '0;
      fifo_val_q[1] <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      inflight_q    <= inflight_d;
      infl_col_q    <= infl_col_d;
      fifo_col_q    <= fifo_col_d;
      fifo_val_q    <= fifo_val_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

endmodule
